// File: rtl/module_display_7seg_scan.sv
// module_display_7seg_scan
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A 16-bit packed BCD word {d3,d2,d1,d0} is captured on `load`. Each digit
// gets one slot of TICK_DIV cycles. The first BLANK_CYCLES cycles of every
// slot keep all anodes off so the previous digit does not ghost.
// seg, an and digit_sel are registered and lag the internal scan state by
// one cycle.
//
// Optional build macro: DISPLAY_LZ_BLANK_EN
//   defined   : leading-zero suppression (digit 0 is always shown)
//   undefined : all four digits are always shown
//
// Slot phase FSM
//   state    | meaning
//   ST_BLANK | start of a slot; all anodes and segments off
//   ST_SHOW  | rest of the slot; the selected digit is driven

module module_display_7seg_scan #(
   parameter int CLK_FREQ_HZ  = 27000000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] bcd_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [1:0]  digit_sel
);

   localparam int TICK_DIV = CLK_FREQ_HZ / REFRESH_HZ;
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TW-1:0] LP_TICK_LAST  = TW'(TICK_DIV - 1);
   // Only meaningful when BLANK_CYCLES > 0; the FSM never looks at it otherwise.
   localparam logic [TW-1:0] LP_BLANK_LAST = TW'(BLANK_CYCLES - 1);
   localparam bit            LP_HAS_BLANK  = (BLANK_CYCLES > 0);

   localparam logic [6:0] LP_SEG_OFF = 7'b1111111;
   localparam logic [3:0] LP_AN_OFF  = 4'b1111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } phase_t;

   logic [TW-1:0] r_tick;
   logic [1:0]    r_idx;
   logic [15:0]   r_digits;
   phase_t        r_phase;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;
   logic [1:0]    r_sel;

   logic          w_wrap;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg_dec;
   logic          w_dark;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign w_wrap = (r_tick == LP_TICK_LAST);

   // Select the nibble belonging to the slot currently being scanned.
   always_comb begin
      w_nib = r_digits[3:0];
      case (r_idx)
         2'd0:    w_nib = r_digits[3:0];
         2'd1:    w_nib = r_digits[7:4];
         2'd2:    w_nib = r_digits[11:8];
         default: w_nib = r_digits[15:12];
      endcase
   end

   assign w_seg_dec = f_decode(w_nib);

`ifdef DISPLAY_LZ_BLANK_EN
   // A slot is dark when it and every more-significant digit are zero.
   always_comb begin
      w_dark = 1'b0;
      case (r_idx)
         2'd3:    w_dark = (r_digits[15:12] == 4'd0);
         2'd2:    w_dark = (r_digits[15:8]  == 8'd0);
         2'd1:    w_dark = (r_digits[15:4]  == 12'd0);
         default: w_dark = 1'b0;
      endcase
   end
`else
   assign w_dark = 1'b0;
`endif

   // Slot timer and scan index: the tick wraps every TICK_DIV cycles and
   // the index then moves to the next digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tick <= '0;
         r_idx  <= 2'd0;
      end else if (w_wrap) begin
         r_tick <= '0;
         r_idx  <= r_idx + 2'd1;
      end else begin
         r_tick <= r_tick + TW'(1);
      end
   end

   // Digit capture; a load always wins and needs no handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_digits <= 16'h0000;
      end else if (load) begin
         r_digits <= bcd_in;
      end
   end

   // Slot phase FSM with registered drives. The drives are computed from the
   // pre-edge phase, index and digit word, which gives the fixed one-cycle lag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (LP_HAS_BLANK) r_phase <= ST_BLANK;
         else              r_phase <= ST_SHOW;
         r_seg <= LP_SEG_OFF;
         r_an  <= LP_AN_OFF;
         r_sel <= 2'd0;
      end else begin
         case (r_phase)
            ST_BLANK: begin
               if (r_tick == LP_BLANK_LAST) r_phase <= ST_SHOW;
            end
            default: begin
               if (w_wrap && LP_HAS_BLANK) r_phase <= ST_BLANK;
            end
         endcase

         r_sel <= r_idx;
         if ((r_phase == ST_SHOW) && !w_dark) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg_dec;
         end else begin
            r_an  <= LP_AN_OFF;
            r_seg <= LP_SEG_OFF;
         end
      end
   end

   assign seg       = r_seg;
   assign an        = r_an;
   assign digit_sel = r_sel;

endmodule

// File: tb/tb_module_display_7seg_scan.sv
// Testbench for module_display_7seg_scan. The stimulus process predicts each
// cycle's drives from a slot/position model and queues them. A separate
// monitor pops one entry after every clock edge and compares it to the DUT.
// Honors DISPLAY_LZ_BLANK_EN when it is defined for the build.

module tb_module_display_7seg_scan;

   localparam int CLK_HZ = 1000;
   localparam int REF_HZ = 100;
   localparam int BLANK  = 2;
   localparam int TD     = CLK_HZ / REF_HZ;
   localparam int PERIOD = 4 * TD;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        load   = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [1:0]  digit_sel;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic [1:0] sel;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          pos         = 0;
   logic [15:0] mdl_digits  = 16'h0000;
   logic [6:0]  seg_tab [16];

   module_display_7seg_scan #(
      .CLK_FREQ_HZ (CLK_HZ),
      .REFRESH_HZ  (REF_HZ),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .bcd_in   (bcd_in),
      .seg      (seg),
      .an       (an),
      .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   // Index of the most significant nonzero digit (0 when the word is zero).
   // With suppression on, every slot above it is dark.
   function automatic bit is_dark(input int slot, input logic [15:0] d);
      int top;
      bit lz_en;
      top = 0;
      for (int i = 0; i < 4; i++)
         if (((d >> (4 * i)) & 16'hF) != 0) top = i;
`ifdef DISPLAY_LZ_BLANK_EN
      lz_en = 1'b1;
`else
      lz_en = 1'b0;
`endif
      return lz_en && (slot > top);
   endfunction

   // One clock: drive inputs, predict the drives after the coming edge, and
   // advance the model.
   task automatic step(input bit rst, input bit ld, input logic [15:0] d);
      exp_t e;
      int   slot;
      int   t;
      @(negedge clk);
      rst_n  = ~rst;
      load   = ld;
      bcd_in = d;
      if (rst) begin
         e.seg = 7'b1111111;
         e.an  = 4'b1111;
         e.sel = 2'd0;
      end else begin
         slot  = pos / TD;
         t     = pos % TD;
         e.sel = 2'(slot);
         if (t < BLANK || is_dark(slot, mdl_digits)) begin
            e.seg = 7'b1111111;
            e.an  = 4'b1111;
         end else begin
            e.an  = 4'(~(4'b0001 << slot));
            e.seg = seg_tab[mdl_digits[slot*4 +: 4]];
         end
      end
      sb_q.push_back(e);
      if (rst) begin
         pos        = 0;
         mdl_digits = 16'h0000;
      end else begin
         pos = (pos + 1) % PERIOD;
         if (ld) mdl_digits = d;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, 1'b0, 16'h0000);
   endtask

   // Monitor: one queued prediction per clock edge, checked 1 time unit later.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if ({seg, an, digit_sel} !== e) begin
               miscompares++;
               $display("FAIL scan vec %0d t=%0t: got seg=%b an=%b sel=%0d, expected seg=%b an=%b sel=%0d",
                        vectors, $time, seg, an, digit_sel, e.seg, e.an, e.sel);
            end
         end
      end
   end

   initial begin
      int          guard;
      int          r;
      logic [15:0] d;
      bit          rr;
      bit          ll;

      seg_tab[0]  = 7'b1000000;  seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100;  seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001;  seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010;  seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000;  seg_tab[9]  = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

      // Reset for 3 cycles, then observe the first blank/active transition.
      repeat (3) step(1'b1, 1'b0, 16'h0000);
      run(8);

      // Tens/units pattern, then all zeros, then a dash digit.
      step(1'b0, 1'b1, 16'h0081);  run(45);
      step(1'b0, 1'b1, 16'h0000);  run(42);
      step(1'b0, 1'b1, 16'h00A5);  run(42);

      // Load on the exact edge where the scan wraps from slot 3 to slot 0.
      guard = 0;
      while (pos != PERIOD - 1 && guard < PERIOD) begin
         step(1'b0, 1'b0, 16'h0000);
         guard++;
      end
      step(1'b0, 1'b1, 16'h0042);  run(45);

      // Reset in the middle of slot 2; afterwards the display shows zeros.
      step(1'b0, 1'b1, 16'h1234);
      guard = 0;
      while (pos != 2 * TD + 4 && guard < PERIOD) begin
         step(1'b0, 1'b0, 16'h0000);
         guard++;
      end
      step(1'b1, 1'b0, 16'h0000);
      run(45);

      // Random loads and occasional resets; zero nibbles are favored so that
      // leading-zero cases come up often.
      repeat (600) begin
         r  = int'($urandom_range(0, 99));
         rr = (r < 2);
         ll = (r >= 2 && r < 15);
         for (int i = 0; i < 4; i++)
            d[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         step(rr, ll, d);
      end

      repeat (3) @(negedge clk);
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending predictions, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
